// File: rtl/eth_pkg.sv
// Shared Ethernet constants, TX framer state type and FCS byte helper.
package eth_pkg;

  localparam logic [7:0]  ETH_PREAMBLE    = 8'h55;
  localparam logic [7:0]  ETH_SFD         = 8'hD5;
  localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB88320;
  localparam logic [31:0] CRC32_INIT      = 32'hFFFFFFFF;

  typedef enum logic [2:0] {
    StIdle,
    StPreamble,
    StSfd,
    StData,
    StPad,
    StFcs,
    StIfg,
    StAbort
  } tx_state_t;

  // FCS is the inverted CRC register, sent least-significant byte first.
  function automatic logic [7:0] fcs_byte(input logic [31:0] crc, input logic [1:0] idx);
    logic [31:0] shifted;
    shifted = (~crc) >> {idx, 3'b000};
    return shifted[7:0];
  endfunction

endpackage

// File: rtl/crc32_d8.sv
// Combinational CRC-32 update for one byte, reflected polynomial, LSB of the byte first.
// Shared with the RX FCS checker.
module crc32_d8
  import eth_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [7:0]  data,
  output logic [31:0] crc_out
);

  logic [31:0] c;

  // Eight serial LFSR steps unrolled into one combinational stage.
  always_comb begin
    c = crc_in;
    for (int i = 0; i < 8; i++) begin
      if (c[0] ^ data[i]) begin
        c = (c >> 1) ^ CRC32_POLY_REFL;
      end else begin
        c = c >> 1;
      end
    end
    crc_out = c;
  end

endmodule

// File: rtl/eth_tx_framer.sv
// Ethernet TX framer: wraps an upstream packet stream with preamble, SFD, zero padding and
// CRC-32 FCS onto a GMII-style byte bus, aborts on underrun/oversize and enforces the IFG.
module eth_tx_framer
  import eth_pkg::*;
#(
  parameter int unsigned PREAMBLE_BYTES = 7,
  parameter int unsigned MIN_FRAME      = 64,
  parameter int unsigned MAX_FRAME      = 1518,
  parameter int unsigned IFG_BYTES      = 12
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  s_data,
  input  logic        s_valid,
  input  logic        s_last,
  output logic        s_ready,
  output logic [7:0]  txd,
  output logic        tx_en,
  output logic        tx_er,
  output logic        busy,
  output logic [15:0] frame_cnt,
  output logic [15:0] err_cnt
);

  // Pad target and payload limit both exclude the 4 FCS bytes.
  localparam int unsigned PadTargetInt = (MIN_FRAME > 4) ? MIN_FRAME - 4 : 0;
  localparam int unsigned MaxLenInt    = MAX_FRAME - 4;
  localparam logic [10:0] PadTarget    = PadTargetInt[10:0];
  localparam logic [10:0] MaxLen       = MaxLenInt[10:0];

  localparam int unsigned IfgW = $clog2(IFG_BYTES + 1);
  localparam int unsigned PreW = $clog2(PREAMBLE_BYTES + 1);
  localparam logic [IfgW-1:0] IfgLast = IfgW'(IFG_BYTES - 1);
  localparam logic [PreW-1:0] PreLast = PreW'(PREAMBLE_BYTES);
  localparam logic [PreW-1:0] PreOne  = PreW'(1);

  tx_state_t       state_q;
  logic [7:0]      txd_q;
  logic            tx_en_q;
  logic            tx_er_q;
  logic            busy_q;
  logic [15:0]     frame_cnt_q;
  logic [15:0]     err_cnt_q;
  logic [31:0]     crc_q;
  logic [10:0]     len_q;
  logic [PreW-1:0] pre_cnt_q;
  logic [2:0]      fcs_idx_q;
  logic [IfgW-1:0] ifg_cnt_q;
  // Set while the remainder of an aborted packet is still being swallowed.
  logic            drain_q;

  logic [7:0]  crc_byte;
  logic [31:0] crc_next;
  logic [10:0] len_inc;

  // Pad bytes enter the CRC as zeros; otherwise the accepted input byte does.
  assign crc_byte = (state_q == StPad) ? 8'h00 : s_data;
  assign len_inc  = len_q + 11'd1;

  crc32_d8 u_crc (
    .crc_in  (crc_q),
    .data    (crc_byte),
    .crc_out (crc_next)
  );

  // Ready is decoded from state: open from the SFD cycle through the payload, and during
  // the post-abort drain.
  always_comb begin
    s_ready = 1'b0;
    case (state_q)
      StSfd, StData:  s_ready = 1'b1;
      StAbort, StIfg: s_ready = drain_q;
      default:        s_ready = 1'b0;
    endcase
  end

  // Framing FSM with all bus outputs and counters registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      txd_q       <= 8'h00;
      tx_en_q     <= 1'b0;
      tx_er_q     <= 1'b0;
      busy_q      <= 1'b0;
      frame_cnt_q <= 16'h0000;
      err_cnt_q   <= 16'h0000;
      crc_q       <= CRC32_INIT;
      len_q       <= 11'd0;
      pre_cnt_q   <= '0;
      fcs_idx_q   <= 3'd0;
      ifg_cnt_q   <= '0;
      drain_q     <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (s_valid) begin
            state_q   <= StPreamble;
            tx_en_q   <= 1'b1;
            txd_q     <= ETH_PREAMBLE;
            crc_q     <= CRC32_INIT;
            len_q     <= 11'd0;
            pre_cnt_q <= PreOne;
            busy_q    <= 1'b1;
          end
        end

        StPreamble: begin
          if (pre_cnt_q == PreLast) begin
            txd_q   <= ETH_SFD;
            state_q <= StSfd;
          end else begin
            txd_q     <= ETH_PREAMBLE;
            pre_cnt_q <= pre_cnt_q + 1'b1;
          end
        end

        StSfd, StData: begin
          if (!s_valid) begin
            // Underrun: the PHY cannot be stalled, so poison the frame.
            txd_q   <= 8'h00;
            tx_er_q <= 1'b1;
            drain_q <= 1'b1;
            state_q <= StAbort;
          end else if (len_q == MaxLen) begin
            // Oversize: this byte is consumed but discarded.
            txd_q   <= 8'h00;
            tx_er_q <= 1'b1;
            drain_q <= ~s_last;
            state_q <= StAbort;
          end else begin
            txd_q   <= s_data;
            crc_q   <= crc_next;
            len_q   <= len_inc;
            state_q <= StData;
            if (s_last) begin
              fcs_idx_q <= 3'd0;
              state_q   <= (len_inc < PadTarget) ? StPad : StFcs;
            end
          end
        end

        StPad: begin
          txd_q <= 8'h00;
          crc_q <= crc_next;
          len_q <= len_inc;
          if (len_inc == PadTarget) begin
            fcs_idx_q <= 3'd0;
            state_q   <= StFcs;
          end
        end

        StFcs: begin
          // First FCS cycle still shows the last data/pad byte, hence index 4 ends it.
          if (fcs_idx_q == 3'd4) begin
            tx_en_q     <= 1'b0;
            txd_q       <= 8'h00;
            frame_cnt_q <= frame_cnt_q + 16'd1;
            ifg_cnt_q   <= '0;
            state_q     <= StIfg;
          end else begin
            txd_q     <= fcs_byte(crc_q, fcs_idx_q[1:0]);
            fcs_idx_q <= fcs_idx_q + 3'd1;
          end
        end

        StAbort: begin
          tx_en_q   <= 1'b0;
          tx_er_q   <= 1'b0;
          txd_q     <= 8'h00;
          err_cnt_q <= err_cnt_q + 16'd1;
          ifg_cnt_q <= '0;
          state_q   <= StIfg;
          if (drain_q && s_valid && s_last) begin
            drain_q <= 1'b0;
          end
        end

        StIfg: begin
          // Gap cycles are only counted once the aborted packet has fully drained.
          if (drain_q) begin
            if (s_valid && s_last) begin
              drain_q <= 1'b0;
            end
          end else if (ifg_cnt_q == IfgLast) begin
            if (s_valid) begin
              state_q   <= StPreamble;
              tx_en_q   <= 1'b1;
              txd_q     <= ETH_PREAMBLE;
              crc_q     <= CRC32_INIT;
              len_q     <= 11'd0;
              pre_cnt_q <= PreOne;
            end else begin
              state_q <= StIdle;
              busy_q  <= 1'b0;
            end
          end else begin
            ifg_cnt_q <= ifg_cnt_q + 1'b1;
          end
        end

        default: begin
          state_q <= StIdle;
          tx_en_q <= 1'b0;
          tx_er_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign txd       = txd_q;
  assign tx_en     = tx_en_q;
  assign tx_er     = tx_er_q;
  assign busy      = busy_q;
  assign frame_cnt = frame_cnt_q;
  assign err_cnt   = err_cnt_q;

endmodule
